// File: rtl/pred_table_init_ctrl_pkg.sv
// Shared types and widths for the branch predictor init sequencer.
package pred_table_init_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } init_state_t;

    localparam int DEF_DEPTH  = 256;
    localparam int DEF_ADDR_W = 8;
    localparam int BTB_W      = 40;
    localparam int BHT_W      = 2;
    localparam int CKSUM_W    = 16;

    // Folds one table write into a 16-bit contribution for the load checksum.
    function automatic logic [CKSUM_W-1:0] cksum_term(input logic [BTB_W-1:0] btb,
                                                      input logic [BHT_W-1:0] bht);
        return btb[15:0] ^ btb[31:16] ^ {8'h00, btb[39:32]} ^ {14'h0000, bht};
    endfunction

endpackage

// File: rtl/pred_init_cksum.sv
// Accumulates a checksum over one table load and flags a mismatch against the expected value.
// Latency: error flag registered on the edge leaving DONE; cleared on the edge that launches a load.
// Backpressure: none; samples every write strobe unconditionally.
module pred_init_cksum
    import pred_table_init_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               acc_en,
    input  logic               cmp,
    input  logic [BTB_W-1:0]   btb_init,
    input  logic [BHT_W-1:0]   bht_init,
    input  logic [CKSUM_W-1:0] cksum_exp,
    output logic               cksum_err
);

    logic [CKSUM_W-1:0] acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            cksum_err <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            cksum_err <= 1'b0;
        end else begin
            if (acc_en) begin
                acc <= acc + cksum_term(btb_init, bht_init);
            end
            if (cmp) begin
                cksum_err <= (acc != cksum_exp);
            end
        end
    end

endmodule

// File: rtl/pred_table_init_ctrl.sv
// Preloads BTB/BHT from a synchronous init ROM while stalling the PC; PRED_INIT_CKSUM_EN adds a load checksum.
// Latency: DEPTH+2 cycles from start acceptance to done, one entry written per cycle with no bubbles.
// Backpressure: none; the table write port always accepts, and start is ignored outside IDLE.
module pred_table_init_ctrl
    import pred_table_init_ctrl_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter bit AUTO_START = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  src_addr,
    input  logic [BTB_W-1:0]   src_btb_data,
    input  logic [BHT_W-1:0]   src_bht_data,
    output logic               tbl_we,
    output logic [ADDR_W-1:0]  btb_addr,
    output logic [ADDR_W-1:0]  bht_addr,
    output logic [BTB_W-1:0]   btb_init,
    output logic [BHT_W-1:0]   bht_init,
    output logic               pc_hold,
    output logic               busy,
    output logic               done
`ifdef PRED_INIT_CKSUM_EN
    ,
    input  logic [CKSUM_W-1:0] cksum_exp,
    output logic               cksum_err
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(DEPTH - 1);

    init_state_t       state;
    init_state_t       state_nxt;
    logic              launch;
    logic              auto_pend;
    logic [ADDR_W:0]   cnt;

    // auto_pend stands in for the pending auto-load so pc_hold is high straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            auto_pend <= AUTO_START;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                auto_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (start || auto_pend) begin
                    state_nxt = PRIME;
                    launch    = 1'b1;
                end
            end
            PRIME:   state_nxt = STREAM;
            STREAM:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ROM address runs one ahead of the write index and parks on the last entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            src_addr <= '0;
            btb_addr <= '0;
        end else begin
            btb_addr <= src_addr;
            if (launch) begin
                src_addr <= '0;
            end else if ((state == PRIME || state == STREAM) && src_addr != ADDR_LAST) begin
                src_addr <= src_addr + 1'b1;
            end
            if (state == PRIME) begin
                cnt <= '0;
            end else if (state == STREAM) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tbl_we   = (state == STREAM);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign pc_hold  = busy | auto_pend;
    assign bht_addr = btb_addr;
    assign btb_init = tbl_we ? src_btb_data : '0;
    assign bht_init = tbl_we ? src_bht_data : '0;

`ifdef PRED_INIT_CKSUM_EN
    pred_init_cksum u_cksum (
        .clk       (clk),
        .rst       (rst),
        .clr       (launch),
        .acc_en    (tbl_we),
        .cmp       (done),
        .btb_init  (btb_init),
        .bht_init  (bht_init),
        .cksum_exp (cksum_exp),
        .cksum_err (cksum_err)
    );
`endif

endmodule

// File: tb/tb_pred_table_init_ctrl.sv
// Bench for pred_table_init_ctrl: DEPTH=256 auto-start instance plus a DEPTH=4 manual-start instance.
module tb_pred_table_init_ctrl;

    logic clk;
    logic rst_a, rst_b, start_a, start_b;

    logic [7:0]  a_src, a_btb_addr, a_bht_addr;
    logic [39:0] a_rd_btb, a_btb_init;
    logic [1:0]  a_rd_bht, a_bht_init;
    logic        a_we, a_hold, a_busy, a_done;

    logic [1:0]  b_src, b_btb_addr, b_bht_addr;
    logic [39:0] b_rd_btb, b_btb_init;
    logic [1:0]  b_rd_bht, b_bht_init;
    logic        b_we, b_hold, b_busy, b_done;

`ifdef PRED_INIT_CKSUM_EN
    logic [15:0] a_cksum_exp;
    logic        a_cksum_err, b_cksum_err;
`endif

    logic [39:0] rom_a_btb [256];
    logic [1:0]  rom_a_bht [256];
    logic [39:0] rom_b_btb [4];
    logic [1:0]  rom_b_bht [4];

    int tests = 0;
    int fails = 0;
    int pcyc  = 0;

    pred_table_init_ctrl #(.DEPTH(256), .ADDR_W(8), .AUTO_START(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .src_addr(a_src),
        .src_btb_data(a_rd_btb), .src_bht_data(a_rd_bht), .tbl_we(a_we),
        .btb_addr(a_btb_addr), .bht_addr(a_bht_addr), .btb_init(a_btb_init),
        .bht_init(a_bht_init), .pc_hold(a_hold), .busy(a_busy), .done(a_done)
`ifdef PRED_INIT_CKSUM_EN
        , .cksum_exp(a_cksum_exp), .cksum_err(a_cksum_err)
`endif
    );

    pred_table_init_ctrl #(.DEPTH(4), .ADDR_W(2), .AUTO_START(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .src_addr(b_src),
        .src_btb_data(b_rd_btb), .src_bht_data(b_rd_bht), .tbl_we(b_we),
        .btb_addr(b_btb_addr), .bht_addr(b_bht_addr), .btb_init(b_btb_init),
        .bht_init(b_bht_init), .pc_hold(b_hold), .busy(b_busy), .done(b_done)
`ifdef PRED_INIT_CKSUM_EN
        , .cksum_exp(16'h0000), .cksum_err(b_cksum_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pcyc     <= pcyc + 1;
        a_rd_btb <= rom_a_btb[a_src];
        a_rd_bht <= rom_a_bht[a_src];
        b_rd_btb <= rom_b_btb[b_src];
        b_rd_bht <= rom_b_bht[b_src];
    end

    // Write log for the DEPTH=256 instance.
    int          wq_cyc [$];
    logic [7:0]  wq_addr [$];
    logic [39:0] wq_btb [$];
    logic [1:0]  wq_bht [$];
    int          dq [$];
    int          addr_split = 0;

    always @(negedge clk) begin
        if (a_we) begin
            wq_cyc.push_back(pcyc);
            wq_addr.push_back(a_btb_addr);
            wq_btb.push_back(a_btb_init);
            wq_bht.push_back(a_bht_init);
            if (a_bht_addr != a_btb_addr) addr_split++;
        end
        if (a_done) dq.push_back(pcyc);
    end

    // Per-cycle snapshots of the DEPTH=4 instance.
    typedef struct {
        int          cyc;
        logic        we, hold, done;
        logic [1:0]  addr, bha, src;
        logic [39:0] btb;
        logic [1:0]  bht;
    } snap_t;
    snap_t bq [$];
    snap_t snap;
    bit    mon_b = 1'b0;

    always @(negedge clk) begin
        if (mon_b) begin
            snap.cyc  = pcyc;      snap.we   = b_we;       snap.hold = b_hold;
            snap.done = b_done;    snap.addr = b_btb_addr; snap.bha  = b_bht_addr;
            snap.src  = b_src;     snap.btb  = b_btb_init; snap.bht  = b_bht_init;
            bq.push_back(snap);
        end
    end

    typedef struct {
        int         cyc;
        logic       we;
        logic [7:0] addr;
        logic [7:0] src;
        logic       hold, busy, done;
    } probe_t;
    probe_t probes [9];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_a(input int mode);
        logic [63:0] r;
        for (int k = 0; k < 256; k++) begin
            r = {$urandom(), $urandom()};
            case (mode)
                0: begin rom_a_btb[k] = 40'(k * 3); rom_a_bht[k] = 2'(k); end
                1: begin rom_a_btb[k] = r[39:0];    rom_a_bht[k] = r[41:40]; end
                default: begin rom_a_btb[k] = '0;   rom_a_bht[k] = '0; end
            endcase
        end
    endtask

    task automatic clear_a();
        wq_cyc.delete(); wq_addr.delete(); wq_btb.delete(); wq_bht.delete();
        dq.delete();
        addr_split = 0;
    endtask

    task automatic start_load_a(output int base);
        start_a = 1'b1;
        base    = pcyc;
        step();
        start_a = 1'b0;
    endtask

    // Expected: entry k written at base+2+k with ROM word k, a single done at base+258.
    task automatic check_load(input string tag, input int base);
        int bad;
        bad = 0;
        chk($sformatf("%s write count", tag), 64'(wq_cyc.size()), 64'(256));
        for (int k = 0; k < wq_cyc.size() && k < 256; k++) begin
            if (wq_cyc[k] != base + 2 + k || wq_addr[k] != 8'(k) ||
                wq_btb[k] != rom_a_btb[k] || wq_bht[k] != rom_a_bht[k]) bad++;
        end
        chk($sformatf("%s bad entries", tag), 64'(bad), 64'(0));
        chk($sformatf("%s done count", tag), 64'(dq.size()), 64'(1));
        if (dq.size() > 0) chk($sformatf("%s done cycle", tag), 64'(dq[0] - base), 64'(258));
        chk($sformatf("%s bht_addr vs btb_addr", tag), 64'(addr_split), 64'(0));
    endtask

`ifdef PRED_INIT_CKSUM_EN
    function automatic logic [15:0] model_cksum();
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < 256; k++)
            s = s + (rom_a_btb[k][15:0] ^ rom_a_btb[k][31:16] ^
                     {8'h00, rom_a_btb[k][39:32]} ^ {14'h0, rom_a_bht[k]});
        return s;
    endfunction
`endif

    int          base, cur, c, r, j, p, k;
    int          hb, wb, db, sb, nw, nd;
    logic        act_b, ew;
    logic [39:0] exp_btb;
    logic [1:0]  exp_bht;
    logic [1:0]  exp_src;

    initial begin
        start_a = 1'b0; start_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
`ifdef PRED_INIT_CKSUM_EN
        a_cksum_exp = 16'h0000;
`endif
        probes[0] = '{0,   1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 1'b0};
        probes[1] = '{1,   1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0};
        probes[2] = '{2,   1'b1, 8'd0,   8'd1,   1'b1, 1'b1, 1'b0};
        probes[3] = '{3,   1'b1, 8'd1,   8'd2,   1'b1, 1'b1, 1'b0};
        probes[4] = '{52,  1'b1, 8'd50,  8'd51,  1'b1, 1'b1, 1'b0};
        probes[5] = '{256, 1'b1, 8'd254, 8'd255, 1'b1, 1'b1, 1'b0};
        probes[6] = '{257, 1'b1, 8'd255, 8'd255, 1'b1, 1'b1, 1'b0};
        probes[7] = '{258, 1'b0, 8'd255, 8'd255, 1'b1, 1'b1, 1'b1};
        probes[8] = '{259, 1'b0, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0};
        fill_a(0);
        for (int i = 0; i < 4; i++) begin
            rom_b_btb[i] = {8'(i + 1), $urandom()};
            rom_b_bht[i] = 2'($urandom_range(0, 3));
        end
        repeat (3) step();

        chk("a reset ctrl", 64'({a_we, a_busy, a_done, a_hold, a_src, a_btb_addr, a_bht_addr, a_bht_init}),
            64'({1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'b00}));
        chk("a reset btb_init", 64'(a_btb_init), 64'(0));
        chk("b reset ctrl", 64'({b_we, b_busy, b_done, b_hold, b_src, b_btb_addr}), 64'(0));

        // Auto-start after reset release, ROM word k = k*3.
        rst_b = 1'b1;
        clear_a();
        rst_a = 1'b1;
        base  = pcyc;
        cur   = 0;
        for (int i = 0; i < 9; i++) begin
            while (cur < probes[i].cyc) begin step(); cur++; end
            exp_bht = probes[i].we ? probes[i].addr[1:0] : 2'b00;
            exp_btb = probes[i].we ? 40'(probes[i].addr) * 40'd3 : 40'h0;
            chk($sformatf("probe cycle %0d", probes[i].cyc),
                64'({a_we, a_hold, a_busy, a_done, a_btb_addr, a_src, a_bht_init, a_btb_init}),
                64'({probes[i].we, probes[i].hold, probes[i].busy, probes[i].done,
                     probes[i].addr, probes[i].src, exp_bht, exp_btb}));
        end
        check_load("auto", base);
        chk("b no autostart", 64'({b_busy, b_hold, b_we}), 64'(0));

        // Start pulsed mid-load is dropped.
        fill_a(1);
        step();
        clear_a();
        start_load_a(base);
        repeat (51) step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (217) step();
        check_load("busy start", base);
        chk("busy start idle after", 64'({a_busy, a_hold}), 64'(0));

        // Reset at entry 100, then a fresh auto load from index 0.
        fill_a(1);
        step();
        clear_a();
        start_load_a(base);
        repeat (101) step();
        chk("pre-reset write index", 64'({a_we, a_btb_addr}), 64'({1'b1, 8'd100}));
        rst_a = 1'b0;
        #1;
        chk("mid-load reset ctrl", 64'({a_we, a_hold, a_busy, a_done, a_src, a_btb_addr, a_bht_addr, a_bht_init}),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00}));
        chk("mid-load reset btb_init", 64'(a_btb_init), 64'(0));
        step();
        step();
        clear_a();
        rst_a = 1'b1;
        base  = pcyc;
        repeat (262) step();
        check_load("reset restart", base);

        // DEPTH=4 with start held: loads repeat every DEPTH+3 cycles.
        bq.delete();
        mon_b   = 1'b1;
        start_b = 1'b1;
        c       = pcyc;
        repeat (20) step();
        start_b = 1'b0;
        repeat (4) step();
        mon_b = 1'b0;
        hb = 0; wb = 0; db = 0; sb = 0; nw = 0; nd = 0;
        for (int i = 0; i < bq.size(); i++) begin
            r     = bq[i].cyc - c;
            j     = r / 7;
            p     = r % 7;
            act_b = (j < 3) && (p != 0);
            ew    = act_b && (p >= 2) && (p <= 5);
            if (bq[i].hold != act_b) hb++;
            if (bq[i].done != (act_b && p == 6)) db++;
            if (bq[i].we) nw++;
            if (bq[i].done) nd++;
            if (bq[i].we != ew) wb++;
            else if (ew) begin
                k = p - 2;
                if (bq[i].addr != 2'(k) || bq[i].bha != 2'(k) ||
                    bq[i].btb != rom_b_btb[k] || bq[i].bht != rom_b_bht[k]) wb++;
            end
            exp_src = (p == 1) ? 2'd0 : (p >= 2 && p <= 4) ? 2'(p - 1) : 2'd3;
            if (act_b && bq[i].src != exp_src) sb++;
        end
        chk("d4 snapshot count", 64'(bq.size()), 64'(24));
        chk("d4 pc_hold pattern", 64'(hb), 64'(0));
        chk("d4 write pattern", 64'(wb), 64'(0));
        chk("d4 done pattern", 64'(db), 64'(0));
        chk("d4 src_addr pattern", 64'(sb), 64'(0));
        chk("d4 writes", 64'(nw), 64'(12));
        chk("d4 dones", 64'(nd), 64'(3));

`ifdef PRED_INIT_CKSUM_EN
        fill_a(2);
        a_cksum_exp = 16'h0000;
        start_load_a(base);
        repeat (258) step();
        chk("cksum zero match", 64'(a_cksum_err), 64'(0));
        a_cksum_exp = 16'h0001;
        start_load_a(base);
        repeat (258) step();
        chk("cksum mismatch set", 64'(a_cksum_err), 64'(1));
        step();
        chk("cksum mismatch holds", 64'(a_cksum_err), 64'(1));
        fill_a(1);
        a_cksum_exp = model_cksum();
        start_a = 1'b1;
        chk("cksum held at accept", 64'(a_cksum_err), 64'(1));
        step();
        start_a = 1'b0;
        chk("cksum cleared in prime", 64'(a_cksum_err), 64'(0));
        repeat (258) step();
        chk("cksum random match", 64'(a_cksum_err), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pred_table_init_ctrl.md
# pred_table_init_ctrl

Sequencer that preloads the branch target buffer (BTB) and branch history table (BHT) of the fetch stage from a synchronous init ROM. It walks every table index and drives the shared table write port (`btb_addr`/`bht_addr`/`btb_init`/`bht_init`). While it runs, it holds the PC through `pc_hold`, which feeds the fetch stage's `PCWrite` enable, so no instruction is fetched against a partially loaded predictor. It sits between the top level (reset and re-init request) and the fetch stage.

## Interface
- `DEPTH`, 256: table entries walked; power of two, ≥ 2.
- `ADDR_W`, 8: index width; equals log2(DEPTH).
- `AUTO_START`, 1: 1 means a load starts automatically after reset release.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: re-init request; sampled only in IDLE.
- `src_addr` out ADDR_W: init ROM read address.
- `src_btb_data` in 40: ROM BTB word, valid one cycle after `src_addr`.
- `src_bht_data` in 2: ROM BHT counter, valid one cycle after `src_addr`.
- `tbl_we` out 1: table write strobe.
- `btb_addr` out ADDR_W: BTB write index.
- `bht_addr` out ADDR_W: BHT write index; always equal to `btb_addr`.
- `btb_init` out 40: BTB write data.
- `bht_init` out 2: BHT write data.
- `pc_hold` out 1: 1 stalls the PC (fetch stage `PCWrite` = ~`pc_hold`).
- `busy` out 1: high from PRIME through DONE.
- `done` out 1: one-cycle pulse when the load completes.
- `cksum_exp` in 16 and `cksum_err` out 1: present only with `PRED_INIT_CKSUM_EN`.

## Operation
- States:
  - IDLE
  - PRIME: issue ROM address 0
  - STREAM: write entry k, read entry k+1
  - DONE
- Transitions:
  - IDLE→PRIME when `start`=1, or on the first clock after reset release if `AUTO_START`=1.
  - PRIME→STREAM unconditionally.
  - STREAM→DONE after index DEPTH-1 is written.
  - DONE→IDLE unconditionally.
- Index counter, ADDR_W+1 bits:
  - Cleared in PRIME; increments on every STREAM write.
  - Terminal count is DEPTH-1. The counter never wraps into a second pass.
- `src_addr`:
  - Registered.
  - 0 in PRIME.
  - k+1 in STREAM while k < DEPTH-1; holds DEPTH-1 on the last write.
- `btb_addr`/`bht_addr`: registered, equal to `src_addr` delayed one cycle.
- `btb_init`/`bht_init`:
  - Combinational pass-through of ROM data when `tbl_we`=1.
  - 0 otherwise.
- `tbl_we`: 1 only in STREAM.
- `pc_hold`: 1 in PRIME, STREAM and DONE; 0 in IDLE.
- `start` asserted in any state other than IDLE is ignored and not queued.
- A continuously high `start` produces back-to-back loads separated by exactly one IDLE cycle.
- Reset mid-load:
  - All outputs go to their reset values immediately.
  - The aborted partial load is not resumed.
  - With `AUTO_START`=1, a fresh load begins from index 0.
- Reset values:
  - state IDLE
  - `src_addr`, `btb_addr`, `bht_addr`, `btb_init`, `bht_init` = 0
  - `tbl_we`, `done`, `busy`, `cksum_err` = 0
  - `pc_hold` = `AUTO_START`, so fetch is stalled from reset when auto-load is enabled.

## Timing
- Load accepted at cycle 0 (IDLE with start).
- Cycle 1: PRIME, `busy`=1, `pc_hold`=1.
- Cycles 2..DEPTH+1: STREAM; cycle 2+k writes entry k.
- Cycle DEPTH+2: DONE, `done`=1.
- Cycle DEPTH+3: IDLE, `pc_hold`=0.
- DEPTH=256 gives 258 held cycles after acceptance.
- Write throughput is one entry per cycle, with no bubbles.

## Configuration
- Macro: `PRED_INIT_CKSUM_EN`.
- With the macro defined:
  - A 16-bit accumulator clears in PRIME.
  - On each write it adds `btb_init[15:0]` ^ `btb_init[31:16]` ^ {8'b0, `btb_init[39:32]`} ^ {14'b0, `bht_init`}, modulo 2^16.
  - In DONE the accumulator is compared with `cksum_exp`.
  - `cksum_err` is registered at the DONE→IDLE edge, holds until the next PRIME, and is cleared in PRIME.
- Without the macro: no accumulator, and the `cksum_exp`/`cksum_err` ports are absent.

## Structure
- Shared package:
  - state enum (IDLE, PRIME, STREAM, DONE)
  - default DEPTH/ADDR_W
  - BTB entry width (40) and BHT counter width (2)
  - checksum width (16)
- One sub-module, `pred_init_cksum`: accumulator and compare, instantiated only under `PRED_INIT_CKSUM_EN`.
- FSM and index counter stay in the top module.

## Test plan
- **Auto-start:** reset release with `AUTO_START`=1, ROM word[k]=k*3 → 256 writes at cycles 2..257 with `btb_addr`=k, `btb_init`=k*3; `done` pulses at cycle 258; `pc_hold` falls at cycle 259.
- **Busy start ignored:** `start` pulsed at entry 50 of an active load → exactly 256 writes and a single `done`; no second load follows.
- **Reset mid-load:** `rst`=0 at entry 100 → `tbl_we`=0, `pc_hold`=1, addresses 0 the same cycle; after release, writes restart at index 0.
- **Small DEPTH:** DEPTH=4, `AUTO_START`=0, `start` held high → loads of 4 writes each, one IDLE cycle between successive loads, `src_addr` never exceeds 3.
- **Checksum match:** with `PRED_INIT_CKSUM_EN`, all ROM words 0 and `cksum_exp`=0 → `cksum_err`=0.
- **Checksum mismatch:** same stimulus with `cksum_exp`=16'h0001 → `cksum_err`=1 from IDLE, cleared in the next PRIME.
